// File: rtl/slack_update.sv
// ADMM slack/projection stage: z = clamp(u + y), v = clamp(x + g), one element per cycle.
// Optional max primal residual output enabled by defining SLACK_UPDATE_RESIDUAL_EN.
module slack_update #(
  parameter int unsigned STATE_DIM   = 12,
  parameter int unsigned CONTROL_DIM = 4,
  parameter int unsigned W           = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [CONTROL_DIM*W-1:0] u_k,
  input  logic [CONTROL_DIM*W-1:0] y_k,
  input  logic [CONTROL_DIM*W-1:0] u_min,
  input  logic [CONTROL_DIM*W-1:0] u_max,
  input  logic [STATE_DIM*W-1:0]   x_k,
  input  logic [STATE_DIM*W-1:0]   g_k,
  input  logic [STATE_DIM*W-1:0]   x_min,
  input  logic [STATE_DIM*W-1:0]   x_max,
  output logic [CONTROL_DIM*W-1:0] z_out,
  output logic [STATE_DIM*W-1:0]   v_out,
  output logic [W-1:0]             prim_res,
  output logic                     busy,
  output logic                     done
);

  localparam int unsigned CIW = (CONTROL_DIM > 1) ? $clog2(CONTROL_DIM) : 1;
  localparam int unsigned SIW = (STATE_DIM > 1) ? $clog2(STATE_DIM) : 1;
  localparam int unsigned IW  = (CIW > SIW) ? CIW : SIW;
  localparam logic [IW-1:0] C_LAST = IW'(CONTROL_DIM - 1);
  localparam logic [IW-1:0] S_LAST = IW'(STATE_DIM - 1);
  localparam logic [W-1:0]  MAXV   = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0]  MINV   = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CTRL, STATE} state_t;

  state_t        state;
  logic [IW-1:0] idx;

  logic [CONTROL_DIM*W-1:0] u_s, y_s, umin_s, umax_s;
  logic [STATE_DIM*W-1:0]   x_s, g_s, xmin_s, xmax_s;

  logic signed [W-1:0] a, b, lo, hi, s, r;
  logic signed [W:0]   sum;

  // Operand mux for the current element
  always_comb begin
    a  = '0;
    b  = '0;
    lo = '0;
    hi = '0;
    if (state == STATE) begin
      for (int i = 0; i < int'(STATE_DIM); i++) begin
        if (idx == IW'(i)) begin
          a  = x_s[i*W +: W];
          b  = g_s[i*W +: W];
          lo = xmin_s[i*W +: W];
          hi = xmax_s[i*W +: W];
        end
      end
    end else begin
      for (int i = 0; i < int'(CONTROL_DIM); i++) begin
        if (idx == IW'(i)) begin
          a  = u_s[i*W +: W];
          b  = y_s[i*W +: W];
          lo = umin_s[i*W +: W];
          hi = umax_s[i*W +: W];
        end
      end
    end
  end

  // Saturating add then clamp; an inverted bound pair resolves to lo
  always_comb begin
    sum = {a[W-1], a} + {b[W-1], b};
    if (sum[W] != sum[W-1]) s = sum[W] ? MINV : MAXV;
    else                    s = sum[W-1:0];
    if (lo > hi || s < lo) r = lo;
    else if (s > hi)       r = hi;
    else                   r = s;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      idx    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      z_out  <= '0;
      v_out  <= '0;
      u_s    <= '0;
      y_s    <= '0;
      umin_s <= '0;
      umax_s <= '0;
      x_s    <= '0;
      g_s    <= '0;
      xmin_s <= '0;
      xmax_s <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            u_s    <= u_k;
            y_s    <= y_k;
            umin_s <= u_min;
            umax_s <= u_max;
            x_s    <= x_k;
            g_s    <= g_k;
            xmin_s <= x_min;
            xmax_s <= x_max;
            idx    <= '0;
            busy   <= 1'b1;
            state  <= CTRL;
          end
        end
        CTRL: begin
          for (int i = 0; i < int'(CONTROL_DIM); i++)
            if (idx == IW'(i)) z_out[i*W +: W] <= r;
          if (idx == C_LAST) begin
            idx   <= '0;
            state <= STATE;
          end else begin
            idx <= idx + IW'(1);
          end
        end
        STATE: begin
          for (int i = 0; i < int'(STATE_DIM); i++)
            if (idx == IW'(i)) v_out[i*W +: W] <= r;
          if (idx == S_LAST) begin
            idx   <= '0;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= IDLE;
          end else begin
            idx <= idx + IW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SLACK_UPDATE_RESIDUAL_EN
  logic signed [W:0] diff;
  logic [W:0]        mag;
  logic [W-1:0]      d;

  // |a - r| saturated to the positive word range
  always_comb begin
    diff = {a[W-1], a} - {r[W-1], r};
    mag  = diff[W] ? (W+1)'(-diff) : (W+1)'(diff);
    d    = (mag[W] | mag[W-1]) ? MAXV : mag[W-1:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                       prim_res <= '0;
    else if (state == IDLE && start) prim_res <= '0;
    else if (state != IDLE && d > prim_res) prim_res <= d;
  end
`else
  assign prim_res = '0;
`endif

endmodule

// File: doc/slack_update.md
Name: slack_update

Overview:
- ADMM slack/projection stage of the MPC solver. It runs opposite to the dual update: it consumes the current duals (y, g) and primals (u, x) and produces the new slacks (z, v) that the dual update reads next iteration.
- Computes z = clamp(u + y, u_min, u_max) and v = clamp(x + g, x_min, x_max) serially, one element per cycle, through a single saturating adder and clamp.
- Sits between the primal solve and the dual update in the iteration controller, with a start/busy/done handshake.

Parameters:
- STATE_DIM, 12, number of state elements (v, x, g, x_min, x_max).
- CONTROL_DIM, 4, number of control elements (z, u, y, u_min, u_max).
- W, 16, signed fixed-point word width of all data ports.

Ports:
- clk  input  1  clock.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request an update; accepted only when busy=0.
- u_k  input  W x CONTROL_DIM  primal control, signed.
- y_k  input  W x CONTROL_DIM  control dual, signed.
- u_min  input  W x CONTROL_DIM  lower control bound, signed.
- u_max  input  W x CONTROL_DIM  upper control bound, signed.
- x_k  input  W x STATE_DIM  primal state, signed.
- g_k  input  W x STATE_DIM  state dual, signed.
- x_min  input  W x STATE_DIM  lower state bound, signed.
- x_max  input  W x STATE_DIM  upper state bound, signed.
- z_out  output  W x CONTROL_DIM  new control slack, registered.
- v_out  output  W x STATE_DIM  new state slack, registered.
- prim_res  output  W  max primal residual, non-negative signed (see Optional Feature).
- busy  output  1  high while the update is in progress.
- done  output  1  single-cycle completion pulse.

Behaviour:
- Reset is asynchronous, from clk and reset exactly as decided. It clears z_out, v_out, prim_res, busy, done, the index and the FSM to 0/IDLE.
- Reset mid-operation aborts the update. No done pulse is issued, and outputs read 0 afterwards.
- FSM states and transitions:
  - IDLE: waits for start.
  - CTRL: idx 0..CONTROL_DIM-1, writes z_out.
  - STATE: idx 0..STATE_DIM-1, writes v_out.
- Start acceptance:
  - start with busy=0: snapshot all input arrays into internal registers, set idx=0, busy=1, go to CTRL.
  - Inputs may change after acceptance.
  - start while busy=1 is ignored.
- One element per clock edge while busy:
  - a = snapshot primal, b = snapshot dual.
  - s = a + b, computed at W+1 bits and saturated to [-2^(W-1), 2^(W-1)-1].
  - r = lo if s < lo; hi if s > hi; else s.
  - If lo > hi, r = lo (lower bound wins).
  - r is written to z_out[idx] or v_out[idx] on that edge. All other elements hold their values.
- Phase wrap:
  - CTRL idx=CONTROL_DIM-1 → STATE idx=0.
  - STATE idx=STATE_DIM-1 → IDLE on that same edge, busy→0, done→1 for exactly one cycle.
- Latency: done is high in the cycle following the N-th edge after the start edge, N = CONTROL_DIM + STATE_DIM (16 by default). Throughput is one update per N+1 cycles.
- start sampled in the done cycle (busy=0) is accepted, giving back-to-back updates.
- Outputs hold their last values between updates.
- Partially updated arrays are visible while busy=1. Consumers sample only on done.
- Arithmetic is fixed-point with no scaling (bounds, primals and duals share the same Q format).

Optional Feature:
- Macro: SLACK_UPDATE_RESIDUAL_EN.
- Defined:
  - prim_res is cleared to 0 at start acceptance.
  - Each element cycle computes d = |a - r| at W+1 bits, saturated to 2^(W-1)-1.
  - prim_res <= max(prim_res, d).
  - The final value is valid when done=1 and holds until the next start.
- Undefined: prim_res is tied to 0 and no residual logic is synthesized. All other behaviour is identical.

Test Plan (CONTROL_DIM=4, STATE_DIM=12, W=16):
- Basic: u=100, y=20, u_min=-1000, u_max=1000; x=5, g=-3, x_min=-50, x_max=50 → z_out all 120, v_out all 2. done pulses 16 cycles after start; busy high 16 cycles.
- Clamp: u=900, y=300, u_max=1000 → z=1000. x=-40, g=-30, x_min=-50 → v=-50. prim_res=100 (u-z) with RESIDUAL_EN, 0 without.
- Saturation/inverted bounds: u=32000, y=32000, u_max=32767 → z=32767 (no wrap). Element with lo=10, hi=5, s=7 → r=10.
- Handshake: start pulsed again at cycles 3 and 10 while busy → ignored, single done. start asserted in the done cycle → second update accepted, done 17 cycles after the first done.
- Snapshot: change u_k and y_k to 0 one cycle after start → results still reflect the values captured at start.
- Reset mid-op: assert reset at element 7 → busy=0, done never pulses, z_out/v_out/prim_res=0. The next start completes normally.
